// File: rtl/mismatch_scoreboard_ctrl_pkg.sv
// Shared types and constants for the ref-vs-DUT mismatch scoreboard.
package mismatch_sb_pkg;

    localparam int CNT_W_DEF = 32;

    // All-ones value at which the default-width counters stop.
    localparam logic [CNT_W_DEF-1:0] SAT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sb_state_t;

    // Flat encodings used by the state register.
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    typedef struct packed {
        logic [CNT_W_DEF-1:0] clocks;
        logic [CNT_W_DEF-1:0] errors;
        logic [CNT_W_DEF-1:0] first_err_time;
    } sb_stats_t;

endpackage

// File: rtl/mismatch_scoreboard_ctrl_if.sv
// Run-control and compare-data bundle between the stimulus/compare
// environment (master) and the scoreboard controller (slave).
interface mismatch_scoreboard_ctrl_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 32
);
    logic             start;
    logic             sample_valid;
    logic [WIDTH-1:0] ref_data;
    logic [WIDTH-1:0] dut_data;
    logic             stim_en;
    logic             busy;
    logic             done;
    logic             pass;
    logic             timeout;
    logic [CNT_W-1:0] clocks;
    logic [CNT_W-1:0] errors;
    logic [CNT_W-1:0] first_err_time;
    logic             first_err_vld;
    logic [WIDTH-1:0] err_bits;

    modport master (
        output start, sample_valid, ref_data, dut_data,
        input  stim_en, busy, done, pass, timeout,
        input  clocks, errors, first_err_time, first_err_vld, err_bits
    );

    modport slave (
        input  start, sample_valid, ref_data, dut_data,
        output stim_en, busy, done, pass, timeout,
        output clocks, errors, first_err_time, first_err_vld, err_bits
    );
endinterface

// File: rtl/mismatch_scoreboard_ctrl_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear has priority over increment so a new run always starts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mismatch_scoreboard_ctrl.sv
// Run controller and scoreboard: sequences one compare run, counts samples
// and mismatches, records the first mismatch time and reports pass/fail.
//
// state | meaning
// IDLE  | after reset, waiting for start; stats zero
// RUN   | stimulus enabled, samples being compared, cycle timer running
// DONE  | run finished (sample limit or timeout); stats and verdict held
module mismatch_scoreboard_ctrl
    import mismatch_sb_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int CNT_W       = 32,
    parameter int MAX_SAMPLES = 100,
    parameter int TIMEOUT     = 100000
) (
    input  logic                     clk,
    input  logic                     reset,
    mismatch_scoreboard_ctrl_if.slave sb
);
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(MAX_SAMPLES - 1);
    localparam logic [CNT_W-1:0] LAST_CYC    = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] first_err_time_q, first_err_time_d;
    logic             first_err_vld_q, first_err_vld_d;
    logic [WIDTH-1:0] err_bits_q, err_bits_d;

    logic [CNT_W-1:0] clocks_q;
    logic [CNT_W-1:0] errors_q;
    logic [CNT_W-1:0] cyc_q;

    logic             in_run;
    logic             run_start;
    logic             sample_take;
    logic [WIDTH-1:0] diff;
    logic             mismatch_take;
    logic             last_sample;
    logic             last_cyc;

    assign in_run        = (state_q == ST_RUN);
    assign run_start     = sb.start && !in_run;
    assign sample_take   = in_run && sb.sample_valid;
    assign diff          = sb.ref_data ^ sb.dut_data;
    assign mismatch_take = sample_take && (|diff);
    assign last_sample   = sample_take && (clocks_q == LAST_SAMPLE);
    assign last_cyc      = in_run && (cyc_q == LAST_CYC);

    sat_counter #(.CNT_W(CNT_W)) u_clocks (
        .clk   (clk),
        .reset (reset),
        .clr_i (run_start),
        .inc_i (sample_take),
        .cnt_o (clocks_q)
    );

    sat_counter #(.CNT_W(CNT_W)) u_errors (
        .clk   (clk),
        .reset (reset),
        .clr_i (run_start),
        .inc_i (mismatch_take),
        .cnt_o (errors_q)
    );

    // Run-cycle timer: zero on the first RUN cycle, frozen outside RUN.
    sat_counter #(.CNT_W(CNT_W)) u_cyc (
        .clk   (clk),
        .reset (reset),
        .clr_i (run_start),
        .inc_i (in_run),
        .cnt_o (cyc_q)
    );

    // Next-state and stat-update decisions for the run sequencer.
    always_comb begin
        state_d          = state_q;
        timeout_d        = timeout_q;
        first_err_time_d = first_err_time_q;
        first_err_vld_d  = first_err_vld_q;
        err_bits_d       = err_bits_q;

        case (state_q)
            ST_RUN: begin
                if (last_sample || last_cyc) begin
                    state_d = ST_DONE;
                end
                // A sample finishing the run on the timeout edge still counts
                // as a clean sample-limit finish.
                if (last_cyc && !last_sample) begin
                    timeout_d = 1'b1;
                end
                if (sample_take) begin
                    err_bits_d = err_bits_q | diff;
                end
                if (mismatch_take && !first_err_vld_q) begin
                    first_err_time_d = cyc_q;
                    first_err_vld_d  = 1'b1;
                end
            end
            default: begin
                if (sb.start) begin
                    state_d          = ST_RUN;
                    timeout_d        = 1'b0;
                    first_err_time_d = '0;
                    first_err_vld_d  = 1'b0;
                    err_bits_d       = '0;
                end
            end
        endcase
    end

    // State and stat registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            timeout_q        <= 1'b0;
            first_err_time_q <= '0;
            first_err_vld_q  <= 1'b0;
            err_bits_q       <= '0;
        end else begin
            state_q          <= state_d;
            timeout_q        <= timeout_d;
            first_err_time_q <= first_err_time_d;
            first_err_vld_q  <= first_err_vld_d;
            err_bits_q       <= err_bits_d;
        end
    end

    assign sb.stim_en        = in_run;
    assign sb.busy           = in_run;
    assign sb.done           = (state_q == ST_DONE);
    assign sb.pass           = (state_q == ST_DONE) && (errors_q == '0) && !timeout_q;
    assign sb.timeout        = timeout_q;
    assign sb.clocks         = clocks_q;
    assign sb.errors         = errors_q;
    assign sb.first_err_time = first_err_time_q;
    assign sb.first_err_vld  = first_err_vld_q;
    assign sb.err_bits       = err_bits_q;

endmodule

// File: tb/tb_mismatch_scoreboard_ctrl.sv
// Directed bench for mismatch_scoreboard_ctrl: three instances cover the
// sample-limit runs, the timeout run and the limit/timeout coincidence.
module tb_mismatch_scoreboard_ctrl;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    int   n_checks = 0;
    int   n_errs   = 0;

    always #5 clk = ~clk;

    mismatch_scoreboard_ctrl_if #(.WIDTH(4), .CNT_W(32)) if_a ();
    mismatch_scoreboard_ctrl_if #(.WIDTH(4), .CNT_W(32)) if_b ();
    mismatch_scoreboard_ctrl_if #(.WIDTH(4), .CNT_W(32)) if_c ();

    mismatch_scoreboard_ctrl #(.WIDTH(4), .CNT_W(32), .MAX_SAMPLES(100), .TIMEOUT(1000)) dut_a (
        .clk(clk), .reset(rst_a), .sb(if_a)
    );
    mismatch_scoreboard_ctrl #(.WIDTH(4), .CNT_W(32), .MAX_SAMPLES(100), .TIMEOUT(50)) dut_b (
        .clk(clk), .reset(rst_b), .sb(if_b)
    );
    mismatch_scoreboard_ctrl #(.WIDTH(4), .CNT_W(32), .MAX_SAMPLES(20), .TIMEOUT(20)) dut_c (
        .clk(clk), .reset(rst_c), .sb(if_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_a_cleared(input string tag);
        check({tag, "_busy"},    32'(if_a.busy),          32'd0);
        check({tag, "_stim"},    32'(if_a.stim_en),       32'd0);
        check({tag, "_done"},    32'(if_a.done),          32'd0);
        check({tag, "_pass"},    32'(if_a.pass),          32'd0);
        check({tag, "_tmo"},     32'(if_a.timeout),       32'd0);
        check({tag, "_clocks"},  if_a.clocks,             32'd0);
        check({tag, "_errors"},  if_a.errors,             32'd0);
        check({tag, "_fet"},     if_a.first_err_time,     32'd0);
        check({tag, "_fevld"},   32'(if_a.first_err_vld), 32'd0);
        check({tag, "_errbits"}, 32'(if_a.err_bits),      32'd0);
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        if_a.start = 1'b0; if_a.sample_valid = 1'b0; if_a.ref_data = 4'h0; if_a.dut_data = 4'h0;
        if_b.start = 1'b0; if_b.sample_valid = 1'b0; if_b.ref_data = 4'h0; if_b.dut_data = 4'h0;
        if_c.start = 1'b0; if_c.sample_valid = 1'b0; if_c.ref_data = 4'h5; if_c.dut_data = 4'h5;
        tick();
        tick();
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        check_a_cleared("reset");

        // valid in IDLE is ignored
        if_a.sample_valid = 1'b1;
        tick();
        check("idle_valid_clocks", if_a.clocks, 32'd0);
        check("idle_valid_busy", 32'(if_a.busy), 32'd0);

        // Run 1: identical data, 100 samples
        if_a.start = 1'b1;
        tick();
        if_a.start = 1'b0;
        check("r1_busy", 32'(if_a.busy), 32'd1);
        check("r1_stim", 32'(if_a.stim_en), 32'd1);
        check("r1_clocks0", if_a.clocks, 32'd0);
        for (int k = 0; k < 99; k++) tick();
        check("r1_busy99", 32'(if_a.busy), 32'd1);
        check("r1_clocks99", if_a.clocks, 32'd99);
        check("r1_pass_run", 32'(if_a.pass), 32'd0);
        tick();
        if_a.sample_valid = 1'b0;
        check("r1_done", 32'(if_a.done), 32'd1);
        check("r1_pass", 32'(if_a.pass), 32'd1);
        check("r1_clocks", if_a.clocks, 32'd100);
        check("r1_errors", if_a.errors, 32'd0);
        check("r1_fevld", 32'(if_a.first_err_vld), 32'd0);
        check("r1_stim_off", 32'(if_a.stim_en), 32'd0);
        tick();
        check("r1_hold_done", 32'(if_a.done), 32'd1);
        check("r1_hold_clocks", if_a.clocks, 32'd100);

        // Run 2: start from DONE clears stats, mismatches at samples 10 and 40
        if_a.start = 1'b1;
        tick();
        if_a.start = 1'b0;
        check("r2_busy", 32'(if_a.busy), 32'd1);
        check("r2_done", 32'(if_a.done), 32'd0);
        check("r2_clocks_clr", if_a.clocks, 32'd0);
        for (int k = 0; k < 100; k++) begin
            if_a.sample_valid = 1'b1;
            if_a.dut_data = (k == 10 || k == 40) ? 4'h2 : 4'h0;
            tick();
            if (k == 10) begin
                check("r2_fevld10", 32'(if_a.first_err_vld), 32'd1);
                check("r2_fet10", if_a.first_err_time, 32'd10);
                check("r2_err10", if_a.errors, 32'd1);
            end
            if (k == 9) check("r2_fevld9", 32'(if_a.first_err_vld), 32'd0);
        end
        if_a.sample_valid = 1'b0;
        if_a.dut_data = 4'h0;
        check("r2_done_end", 32'(if_a.done), 32'd1);
        check("r2_errors", if_a.errors, 32'd2);
        check("r2_fet", if_a.first_err_time, 32'd10);
        check("r2_errbits", 32'(if_a.err_bits), 32'd2);
        check("r2_pass", 32'(if_a.pass), 32'd0);
        check("r2_tmo", 32'(if_a.timeout), 32'd0);

        // Run 3: start mid-run is ignored
        if_a.start = 1'b1;
        tick();
        check("r3_errbits_clr", 32'(if_a.err_bits), 32'd0);
        check("r3_fevld_clr", 32'(if_a.first_err_vld), 32'd0);
        check("r3_errors_clr", if_a.errors, 32'd0);
        for (int k = 0; k < 100; k++) begin
            if_a.start = (k == 30);
            if_a.sample_valid = 1'b1;
            tick();
            if (k == 30) begin
                check("r3_clocks31", if_a.clocks, 32'd31);
                check("r3_busy31", 32'(if_a.busy), 32'd1);
            end
            if (k == 98) check("r3_busy99", 32'(if_a.busy), 32'd1);
        end
        if_a.start = 1'b0;
        check("r3_done", 32'(if_a.done), 32'd1);
        check("r3_clocks", if_a.clocks, 32'd100);
        check("r3_pass", 32'(if_a.pass), 32'd1);

        // Run 4: reset at sample 60 aborts the run
        if_a.start = 1'b1;
        tick();
        if_a.start = 1'b0;
        for (int k = 0; k < 60; k++) tick();
        check("r4_clocks60", if_a.clocks, 32'd60);
        rst_a = 1'b1;
        tick();
        check_a_cleared("r4_reset");
        rst_a = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("r4_no_done", 32'(if_a.done), 32'd0);
        check("r4_idle", 32'(if_a.busy), 32'd0);
        check("r4_clocks_idle", if_a.clocks, 32'd0);
        if_a.sample_valid = 1'b0;

        // Timeout run: no valid samples, TIMEOUT=50
        if_b.start = 1'b1;
        tick();
        if_b.start = 1'b0;
        for (int k = 0; k < 49; k++) tick();
        check("to_busy49", 32'(if_b.busy), 32'd1);
        check("to_tmo49", 32'(if_b.timeout), 32'd0);
        tick();
        check("to_done", 32'(if_b.done), 32'd1);
        check("to_tmo", 32'(if_b.timeout), 32'd1);
        check("to_pass", 32'(if_b.pass), 32'd0);
        check("to_clocks", if_b.clocks, 32'd0);
        check("to_stim", 32'(if_b.stim_en), 32'd0);

        // Sample limit and timeout coincide: limit wins
        if_c.start = 1'b1;
        tick();
        if_c.start = 1'b0;
        if_c.sample_valid = 1'b1;
        for (int k = 0; k < 19; k++) tick();
        check("co_busy19", 32'(if_c.busy), 32'd1);
        check("co_clocks19", if_c.clocks, 32'd19);
        tick();
        if_c.sample_valid = 1'b0;
        check("co_done", 32'(if_c.done), 32'd1);
        check("co_clocks", if_c.clocks, 32'd20);
        check("co_tmo", 32'(if_c.timeout), 32'd0);
        check("co_pass", 32'(if_c.pass), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
